sobel_window_core: RTL and testbench

SOBEL_WINDOW_CORE -- requirements
Module: sobel_window_core

---
 rtl/sobel_pkg.sv | 18 +
 rtl/sobel_line_buf.sv | 47 ++++
 rtl/sobel_window_core.sv | 168 ++++++++++++++++
 tb/tb_sobel_window_core.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared widths and saturation helpers for the Sobel window core.
package sobel_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned MAG_W      = 11;
    localparam int unsigned GRAD_W     = 12;

    function automatic logic [MAG_W-1:0] sat_limit(input int unsigned data_w);
        return MAG_W'((1 << data_w) - 1);
    endfunction

    localparam logic [MAG_W-1:0] MAG_SAT = sat_limit(DATA_W_DEF);

    function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        return g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-line simple dual-port buffer holding rows r-1 and r-2, registered read.
module sobel_line_buf #(
    parameter int unsigned Depth = 640,
    parameter int unsigned DataW = 8,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_l1_i,
    input  logic [DataW-1:0] wdata_l2_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_l1_o,
    output logic [DataW-1:0] rdata_l2_o
);

    logic [DataW-1:0] mem_l1 [Depth];
    logic [DataW-1:0] mem_l2 [Depth];
    logic [DataW-1:0] rd_l1_q, rd_l1_d;
    logic [DataW-1:0] rd_l2_q, rd_l2_d;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_l1[waddr_i] <= wdata_l1_i;
            mem_l2[waddr_i] <= wdata_l2_i;
        end
    end

    always_comb begin
        rd_l1_d = rd_l1_q;
        rd_l2_d = rd_l2_q;
        if (re_i) begin
            rd_l1_d = mem_l1[raddr_i];
            rd_l2_d = mem_l2[raddr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        rd_l1_q <= rd_l1_d;
        rd_l2_q <= rd_l2_d;
    end

    assign rdata_l1_o = rd_l1_q;
    assign rdata_l2_o = rd_l2_q;

endmodule

// File: rtl/sobel_window_core.sv
// Streaming 3x3 Sobel magnitude with line buffers and a whole-pipeline stall.
module sobel_window_core
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    input  logic              in_sof,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] thresh,
    output logic [DATA_W-1:0] out_mag,
    output logic              out_edge,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_vld,
    input  logic              out_rdy
);

    localparam int unsigned ColW = $clog2(IMG_WIDTH);
    localparam int unsigned RowW = $clog2(IMG_HEIGHT);
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
    localparam logic [MAG_W-1:0] SatMax = sat_limit(DATA_W);

    function automatic logic signed [GRAD_W-1:0] ext(input logic [DATA_W-1:0] v);
        return signed'(GRAD_W'(v));
    endfunction

    logic adv, acc;
    logic [ColW-1:0] col_q, col_d, col_eff, col_nxt;
    logic [RowW-1:0] row_q, row_d, row_eff, row_nxt;
    logic [DATA_W-1:0] lb_rd_l1, lb_rd_l2;
    logic [2:0][2:0][DATA_W-1:0] win_q, win_d;
    logic s1_vld_q, s1_vld_d, s1_border_q, s1_border_d;
    logic s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d;
    logic signed [GRAD_W-1:0] gx, gy;
    logic [MAG_W-1:0] mag, mag_sat;
    logic [DATA_W-1:0] out_mag_q, out_mag_d;
    logic out_vld_q, out_vld_d, out_edge_q, out_edge_d;
    logic out_sof_q, out_sof_d, out_eol_q, out_eol_d;

    // Every stage advances together whenever the output register can move.
    assign adv    = ~out_vld_q | out_rdy;
    assign acc    = in_vld & adv;
    assign in_rdy = adv;

    always_comb begin
        col_eff = in_sof ? '0 : col_q;
        row_eff = in_sof ? '0 : row_q;
        col_nxt = col_eff + ColW'(1);
        row_nxt = row_eff;
        if (col_eff == ColLast) begin
            col_nxt = '0;
            row_nxt = (row_eff == RowLast) ? '0 : row_eff + RowW'(1);
        end
        col_d = acc ? col_nxt : col_q;
        row_d = acc ? row_nxt : row_q;
    end

    // Read is prefetched for the next column so data is ready when that pixel lands;
    // a resync mispredicts only on rows 0-1, whose results are masked.
    sobel_line_buf #(
        .Depth (IMG_WIDTH),
        .DataW (DATA_W)
    ) u_line_buf (
        .clk_i      (clk),
        .we_i       (acc),
        .waddr_i    (col_eff),
        .wdata_l1_i (in_data),
        .wdata_l2_i (lb_rd_l1),
        .re_i       (acc),
        .raddr_i    (col_nxt),
        .rdata_l1_o (lb_rd_l1),
        .rdata_l2_o (lb_rd_l2)
    );

    always_comb begin
        win_d = win_q;
        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_rd_l2;
            win_d[1][2] = lb_rd_l1;
            win_d[2][2] = in_data;
        end
    end

    always_comb begin
        s1_vld_d    = s1_vld_q;
        s1_border_d = s1_border_q;
        s1_sof_d    = s1_sof_q;
        s1_eol_d    = s1_eol_q;
        if (adv) begin
            s1_vld_d    = acc;
            s1_border_d = acc & ((row_eff < RowW'(2)) | (col_eff < ColW'(2)));
            s1_sof_d    = acc & (col_eff == '0) & (row_eff == '0);
            s1_eol_d    = acc & (col_eff == ColLast);
        end
    end

    always_comb begin
        gx = (ext(win_q[0][2]) + ext(win_q[1][2]) + ext(win_q[1][2]) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + ext(win_q[1][0]) + ext(win_q[1][0]) + ext(win_q[2][0]));
        gy = (ext(win_q[2][0]) + ext(win_q[2][1]) + ext(win_q[2][1]) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + ext(win_q[0][1]) + ext(win_q[0][1]) + ext(win_q[0][2]));
        mag     = MAG_W'(abs_grad(gx)) + MAG_W'(abs_grad(gy));
        mag_sat = (mag > SatMax) ? SatMax : mag;
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_mag_d  = out_mag_q;
        out_edge_d = out_edge_q;
        out_sof_d  = out_sof_q;
        out_eol_d  = out_eol_q;
        if (adv) begin
            out_vld_d  = s1_vld_q;
            out_mag_d  = (s1_vld_q & ~s1_border_q) ? DATA_W'(mag_sat) : '0;
            out_edge_d = out_mag_d > thresh;
            out_sof_d  = s1_vld_q & s1_sof_q;
            out_eol_d  = s1_vld_q & s1_eol_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            s1_vld_q    <= 1'b0;
            s1_border_q <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            out_mag_q   <= '0;
            out_edge_q  <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            s1_vld_q    <= s1_vld_d;
            s1_border_q <= s1_border_d;
            s1_sof_q    <= s1_sof_d;
            s1_eol_q    <= s1_eol_d;
            out_vld_q   <= out_vld_d;
            out_mag_q   <= out_mag_d;
            out_edge_q  <= out_edge_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_mag  = out_mag_q;
    assign out_edge = out_edge_q;
    assign out_sof  = out_sof_q;
    assign out_eol  = out_eol_q;

endmodule

// File: tb/tb_sobel_window_core.sv
// Directed and random checks of sobel_window_core against an image-level Sobel model.
module tb_sobel_window_core;

    localparam int W = 8;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_data;
    logic       in_vld;
    logic       in_sof;
    logic       in_rdy;
    logic [7:0] thresh;
    logic [7:0] out_mag;
    logic       out_edge;
    logic       out_sof;
    logic       out_eol;
    logic       out_vld;
    logic       out_rdy;

    sobel_window_core #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_sof   (in_sof),
        .in_rdy   (in_rdy),
        .thresh   (thresh),
        .out_mag  (out_mag),
        .out_edge (out_edge),
        .out_sof  (out_sof),
        .out_eol  (out_eol),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mag;
        bit edg;
        bit sof;
        bit eol;
    } exp_t;

    exp_t q[$];
    int   img [H][W];
    int   kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    int   ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
    int   mr, mc, mode, thr, pend_pix, acc_cnt;
    bit   pend_sof;
    int   total, bad;
    int   n_res, n_sof, n_eol, n_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int gen_pix();
        case (mode)
            0:       return 100;
            1:       return (mc < 4) ? 0 : 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic set_mode(input int m);
        mode     = m;
        pend_pix = gen_pix();
        pend_sof = (mr == 0 && mc == 0);
    endtask

    // Reference: store the pixel at its frame coordinate and apply the Sobel kernels.
    task automatic model_accept(input int pix, input bit sof);
        exp_t e;
        int sx, sy;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = pix;
        e.mag = 0;
        e.edg = 1'b0;
        if (mr >= 2 && mc >= 2) begin
            sx = 0;
            sy = 0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    sx += kx[i][j] * img[mr-2+i][mc-2+j];
                    sy += ky[i][j] * img[mr-2+i][mc-2+j];
                end
            end
            e.mag = iabs(sx) + iabs(sy);
            if (e.mag > 255) e.mag = 255;
            e.edg = (e.mag > thr);
        end
        e.sof = (mr == 0 && mc == 0);
        e.eol = (mc == W - 1);
        q.push_back(e);
        acc_cnt++;
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end
        pend_pix = gen_pix();
        pend_sof = (mr == 0 && mc == 0);
    endtask

    task automatic step(input bit vld, input bit ordy);
        @(negedge clk);
        in_vld  = vld;
        in_data = 8'(pend_pix);
        in_sof  = pend_sof;
        out_rdy = ordy;
        #1;
        if (out_vld === 1'b1) begin
            chk("result_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                chk("mag", 32'(out_mag), q[0].mag);
                chk("flags", {29'd0, out_edge, out_sof, out_eol},
                    {29'd0, q[0].edg, q[0].sof, q[0].eol});
                if (out_rdy) begin
                    n_res++;
                    n_sof  += int'(out_sof);
                    n_eol  += int'(out_eol);
                    n_edge += int'(out_edge);
                    void'(q.pop_front());
                end
            end
        end
        if (in_vld && in_rdy) model_accept(pend_pix, pend_sof);
    endtask

    task automatic stream_n(input int n);
        int target, k;
        target = acc_cnt + n;
        k = 0;
        while (acc_cnt < target && k < 4 * n + 20) begin
            step(1'b1, 1'b1);
            k++;
        end
        chk("stream_bound", 32'(acc_cnt), target);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 100) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk("drain_done", 32'(q.size()), 0);
    endtask

    task automatic clear_counts();
        n_res  = 0;
        n_sof  = 0;
        n_eol  = 0;
        n_edge = 0;
    endtask

    initial begin
        int target, k;
        total = 0; bad = 0; acc_cnt = 0;
        mr = 0; mc = 0; mode = 0; thr = 0;
        in_vld = 1'b0; in_data = '0; in_sof = 1'b0; out_rdy = 1'b1; thresh = '0;
        clear_counts();
        set_mode(0);

        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_out_mag", 32'(out_mag), 0);
        chk("rst_out_edge", 32'(out_edge), 0);
        chk("rst_out_sof", 32'(out_sof), 0);
        chk("rst_out_eol", 32'(out_eol), 0);
        chk("rst_in_rdy", 32'(in_rdy), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Constant frame: all magnitudes zero, one sof, one eol per line.
        clear_counts();
        stream_n(W * H);
        drain();
        chk("const_results", 32'(n_res), W * H);
        chk("const_sof", 32'(n_sof), 1);
        chk("const_eol", 32'(n_eol), H);

        // Vertical step edge.
        thr = 50;
        thresh = 8'(thr);
        set_mode(1);
        clear_counts();
        stream_n(W * H);
        drain();
        chk("step_edges", 32'(n_edge), 4);
        chk("step_results", 32'(n_res), W * H);

        // Ten-cycle downstream stall mid-line.
        thr = int'($urandom_range(0, 255));
        thresh = 8'(thr);
        set_mode(2);
        clear_counts();
        stream_n(11);
        repeat (10) begin
            step(1'b1, 1'b0);
            chk("stall_in_rdy", 32'(in_rdy), 0);
            chk("stall_out_vld", 32'(out_vld), 1);
        end
        stream_n(W * H - 11);
        drain();
        chk("stall_results", 32'(n_res), W * H);

        // Random valid/ready over three frames.
        thr = int'($urandom_range(0, 255));
        thresh = 8'(thr);
        clear_counts();
        target = acc_cnt + 3 * W * H;
        k = 0;
        while (acc_cnt < target && k < 3000) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3));
            k++;
        end
        chk("rand_bound", 32'(acc_cnt), target);
        drain();
        chk("rand_results", 32'(n_res), 3 * W * H);

        // Resync with in_sof at row 2, col 5.
        stream_n(2 * W + 5);
        pend_sof = 1'b1;
        stream_n(1);
        chk("resync_pos", 32'(mr * W + mc), 1);
        stream_n(W * H - 1);
        drain();

        // Reset mid-frame.
        stream_n(13);
        @(negedge clk);
        in_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", 32'(out_vld), 0);
        chk("midrst_out_mag", 32'(out_mag), 0);
        chk("midrst_in_rdy", 32'(in_rdy), 1);
        q.delete();
        mr = 0;
        mc = 0;
        set_mode(2);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        stream_n(W * H);
        drain();
        chk("midrst_results", 32'(n_res), W * H);
        chk("midrst_sof", 32'(n_sof), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
